// File: rtl/bomb_countdown.sv
// bomb_countdown: MM:SS countdown timer and strike accumulator for the bomb.
// Optional build macro STRIKE_SPEEDUP_EN: the tick period shrinks as strikes
// accumulate (CLK_HZ, 3/4 CLK_HZ, 1/2 CLK_HZ). Without it the period is always
// CLK_HZ. CLK_HZ is expected to be at least 4 so every period is non-zero.
// Signalling: accum_enable and game_won are levels sampled every cycle; strike
// is a one-cycle pulse and is honoured only while in RUN. Every output is a
// flop. state_dbg mirrors the FSM state register for observation.
module bomb_countdown #(
  parameter int CLK_HZ        = 27_000_000,
  parameter int START_MINUTES = 5,
  parameter int START_SECONDS = 0,
  parameter int MAX_STRIKES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       accum_enable,
  input  logic       game_won,
  input  logic       strike,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] strikes,
  output logic       tick,
  output logic       running,
  output logic       exploded,
  output logic [1:0] state_dbg
);

  localparam int PW = $clog2(CLK_HZ + 1);

  localparam logic [3:0] START_MT = 4'(START_MINUTES / 10);
  localparam logic [3:0] START_MO = 4'(START_MINUTES % 10);
  localparam logic [3:0] START_ST = 4'(START_SECONDS / 10);
  localparam logic [3:0] START_SO = 4'(START_SECONDS % 10);
  localparam logic [1:0] MAX_S    = 2'(MAX_STRIKES);
  localparam logic [PW-1:0] PERIOD0 = PW'(CLK_HZ);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_FROZEN   = 2'd2,
    S_EXPLODED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic [PW-1:0] period_cur;
  logic [3:0]    dec_mt, dec_mo, dec_st, dec_so;
  logic [1:0]    strikes_inc;
  logic          advance, terminal, tick_evt, strike_evt;
  logic          at_zero, at_one, final_tick, hit_max;
  logic          tick_d, running_d, exploded_d;

  // Events of this cycle; game_won in RUN suppresses both tick and strike.
  always_comb begin
    advance     = (state_q == S_RUN) && !game_won;
    terminal    = accum_enable && (presc_q == period_cur - PW'(1));
    tick_evt    = advance && terminal;
    strike_evt  = advance && strike;
    strikes_inc = strikes + 2'd1;
    at_zero     = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);
    at_one      = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd1);
    final_tick  = tick_evt && (at_zero || at_one);
    hit_max     = strike_evt && (strikes_inc == MAX_S);
  end

  // BCD minus one second with borrow chain sec_ones -> sec_tens -> min_ones -> min_tens.
  always_comb begin
    dec_mt = min_tens;
    dec_mo = min_ones;
    dec_st = sec_tens;
    dec_so = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_so = sec_ones - 4'd1;
    end else begin
      dec_so = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_st = sec_tens - 4'd1;
      end else begin
        dec_st = 4'd5;
        if (min_ones != 4'd0) begin
          dec_mo = min_ones - 4'd1;
        end else begin
          dec_mo = 4'd9;
          dec_mt = min_tens - 4'd1;
        end
      end
    end
  end

`ifdef STRIKE_SPEEDUP_EN
  localparam logic [PW-1:0] PERIOD1 = PW'((CLK_HZ * 3) / 4);
  localparam logic [PW-1:0] PERIOD2 = PW'(CLK_HZ / 2);

  logic [1:0] strikes_next;

  // Strike count as it will be after this edge, used to pick the next period.
  always_comb begin
    strikes_next = strike_evt ? strikes_inc : strikes;
  end

  // Active period is latched only when the prescaler clears, so a strike never
  // cuts short the interval already in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      period_cur <= PERIOD0;
    end else if (tick_evt) begin
      if (strikes_next == 2'd0)      period_cur <= PERIOD0;
      else if (strikes_next == 2'd1) period_cur <= PERIOD1;
      else                           period_cur <= PERIOD2;
    end
  end
`else
  assign period_cur = PERIOD0;
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state; FROZEN and EXPLODED are left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accum_enable) state_d = S_RUN;
      S_RUN: begin
        if (game_won)                    state_d = S_FROZEN;
        else if (final_tick || hit_max) state_d = S_EXPLODED;
      end
      default: state_d = state_q;
    endcase
  end

  // FSM outputs, computed from the next state so the flops line up with it.
  always_comb begin
    tick_d     = tick_evt;
    running_d  = (state_d == S_RUN);
    exploded_d = (state_d == S_EXPLODED);
  end

  // Registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick     <= 1'b0;
      running  <= 1'b0;
      exploded <= 1'b0;
    end else begin
      tick     <= tick_d;
      running  <= running_d;
      exploded <= exploded_d;
    end
  end

  // Prescaler, time digits and strike counter; 00:00 never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q  <= '0;
      min_tens <= START_MT;
      min_ones <= START_MO;
      sec_tens <= START_ST;
      sec_ones <= START_SO;
      strikes  <= 2'd0;
    end else begin
      if (advance && accum_enable) begin
        presc_q <= terminal ? '0 : presc_q + PW'(1);
      end
      if (tick_evt && !at_zero) begin
        min_tens <= dec_mt;
        min_ones <= dec_mo;
        sec_tens <= dec_st;
        sec_ones <= dec_so;
      end
      if (strike_evt) begin
        strikes <= strikes_inc;
      end
    end
  end

  assign state_dbg = state_q;

endmodule

// File: doc/bomb_countdown.md
# bomb_countdown

Countdown timer and strike accumulator for the bomb. Started by `accum_enable` from `bomb_logic`, it counts down from a configured MM:SS at one step per second of `clock`. It also counts strikes reported by the puzzle modules. It drives BCD digits to the timer display and reports `exploded` and the time-remaining state back to the game FSM.

## Interface
- `CLK_HZ`, 27_000_000, clock cycles per nominal second (tick period at zero strikes)
- `START_MINUTES`, 5, initial minutes, 0–99
- `START_SECONDS`, 0, initial seconds, 0–59
- `MAX_STRIKES`, 3, strike count that detonates the bomb, 1–3
- `clock`  in  1  27 MHz system clock, the only clock
- `reset`  in  1  synchronous, active-high reset
- `accum_enable`  in  1  level; high = start/run, low = pause
- `game_won`  in  1  level from `bomb_logic`; freezes the timer
- `strike`  in  1  one-cycle pulse, OR of all module strike pulses
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  BCD digits of the remaining time
- `strikes`  out  2  current strike count
- `tick`  out  1  one-cycle pulse on each decrement, for the beeper
- `running`  out  1  high in RUN state
- `exploded`  out  1  sticky detonation flag

## Operation
- States: IDLE, RUN, FROZEN, EXPLODED. State register is 2 bits.
- IDLE:
  - Digits hold START_MINUTES:START_SECONDS. strikes=0, prescaler=0.
  - `accum_enable`=1 → RUN.
- RUN:
  - The prescaler increments each cycle while `accum_enable`=1 and holds while it is 0.
  - At terminal count (PERIOD−1): prescaler clears, `tick` pulses, and the time decrements by 1 s.
- Decrement is BCD with borrow:
  - sec_ones 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min_ones.
  - min_ones 0→9 borrows from min_tens.
  - No binary-to-BCD conversion.
- Time reaches 00:00 on a tick → EXPLODED on the same edge.
- `strike` in RUN increments `strikes`. If the new value equals MAX_STRIKES → EXPLODED.
- `game_won`=1 in RUN → FROZEN. Digits and strikes hold.
- FROZEN and EXPLODED are exited only by `reset`.
- `strike` outside RUN is ignored.
- Priority on simultaneous events in RUN:
  - `game_won` beats everything: FROZEN; no decrement, no strike counted.
  - Otherwise, a final tick and a strike in the same cycle both apply; the state goes to EXPLODED.
  - A strike and a non-final tick in the same cycle both apply.
- START = 00:00 with accum_enable → RUN, then EXPLODED on the first tick.

## Timing
- Reset values:
  - state=IDLE, digits=START value, strikes=0.
  - tick=0, running=0, exploded=0, prescaler=0.
- All outputs are registered.
- `running` rises 1 cycle after `accum_enable` is sampled high in IDLE.
- The first `tick` occurs PERIOD cycles after RUN entry. Digits update on the same edge as `tick`.
- `exploded` rises on the edge that enters EXPLODED and stays high.
- `running` falls on that same edge.
- Reset mid-RUN restores every reset value on the next edge. A pending tick is lost.

## Configuration
- `STRIKE_SPEEDUP_EN` defined:
  - PERIOD = CLK_HZ at 0 strikes, (CLK_HZ*3)/4 at 1 strike, CLK_HZ/2 at 2 or more strikes. Values are computed at elaboration.
  - The new period takes effect on the next prescaler clear. The prescaler is not reset at the strike.
- Undefined: PERIOD = CLK_HZ always.

## Test plan
- CLK_HZ=10, START 0:03; reset, then accum_enable=1 → ticks at cycles 10, 20, 30 after RUN entry; digits 0:02, 0:01, 0:00; exploded=1 on the 3rd tick.
- START 1:00, one tick → digits 0:59 (sec_tens=5, sec_ones=9, min_ones=0).
- MAX_STRIKES=3, three strike pulses 5 cycles apart in RUN → strikes=1, 2, 3; exploded on the 3rd; later strikes ignored.
- game_won asserted in the same cycle as the final tick → FROZEN, digits stay 0:01, exploded=0.
- accum_enable dropped for 7 cycles mid-count → next tick is delayed exactly 7 cycles.
- With `STRIKE_SPEEDUP_EN`, CLK_HZ=8, one strike → subsequent tick spacing is 6 cycles; with two strikes it is 4 cycles.
